// File: rtl/ext_pwr_seq_pkg.sv
// ext_pwr_seq_pkg: shared state encoding, control decode and counter sizing for the power sequencer.
package ext_pwr_seq_pkg;

    typedef enum logic [3:0] {
        ST_BOOT, ST_BOOT_HOLD, ST_ON, ST_CLK_OFF, ST_ISO_ON, ST_RST_ON,
        ST_SW_OFF, ST_OFF, ST_SW_ON, ST_CLK_ON, ST_RST_REL, ST_ERR
    } state_e;

    localparam int DEF_STEP_CYCLES = 4;
    localparam int DEF_ACK_TIMEOUT = 64;

    function automatic int cnt_width(input int step, input int timeout);
        return $clog2((step > timeout ? step : timeout) + 1);
    endfunction

    localparam int CNT_W = cnt_width(DEF_STEP_CYCLES, DEF_ACK_TIMEOUT);

    // {switch_no, iso_no, rst_no, clkgate_en_no}; ERR is resolved by the caller
    function automatic logic [3:0] ctl_of(input state_e s);
        case (s)
            ST_ON:               return 4'b0111;
            ST_CLK_OFF:          return 4'b0110;
            ST_ISO_ON:           return 4'b0010;
            ST_RST_ON, ST_SW_ON: return 4'b0000;
            ST_SW_OFF, ST_OFF:   return 4'b1000;
            ST_RST_REL:          return 4'b0011;
            default:             return 4'b0001;
        endcase
    endfunction

endpackage

// File: rtl/ext_pwr_domain_fsm.sv
// ext_pwr_domain_fsm: one power domain's sequencer FSM, step/timeout counter and control decode.
module ext_pwr_domain_fsm
    import ext_pwr_seq_pkg::*;
#(
    parameter int STEP_CYCLES = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       i_off_req,
    input  logic       i_on_req,
    input  logic       i_ack_n,
    output logic [3:0] o_ctl,
    output logic       o_on,
    output logic       o_off,
    output logic       o_busy,
    output logic       o_err,
    output logic       o_drop
);
    localparam int CW = cnt_width(STEP_CYCLES, ACK_TIMEOUT);
    localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT - 1);

    state_e r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [3:0] r_err_ctl;
    logic r_drop;
    logic w_step, w_to, w_off_ok, w_on_ok;

    assign w_step = r_cnt == STEP_LAST;
    assign w_to = r_cnt == TO_LAST;
    assign w_off_ok = i_off_req & ~i_on_req & (r_state == ST_ON);
    assign w_on_ok = i_on_req & ~i_off_req & (r_state == ST_OFF || r_state == ST_ERR);

    // counter restarts on every state change and saturates instead of wrapping
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_BOOT;
            r_cnt <= '0;
            r_err_ctl <= 4'b0001;
            r_drop <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt <= (w_next != r_state) ? '0 : (&r_cnt ? r_cnt : r_cnt + 1'b1);
            r_drop <= (i_off_req | i_on_req) & ~(w_off_ok | w_on_ok);
            if (w_next == ST_ERR && r_state != ST_ERR) r_err_ctl <= ctl_of(r_state);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_BOOT:      w_next = !i_ack_n ? ST_BOOT_HOLD : (w_to ? ST_ERR : ST_BOOT);
            ST_BOOT_HOLD: w_next = w_step ? ST_ON : ST_BOOT_HOLD;
            ST_ON:        w_next = w_off_ok ? ST_CLK_OFF : ST_ON;
            ST_CLK_OFF:   w_next = w_step ? ST_ISO_ON : ST_CLK_OFF;
            ST_ISO_ON:    w_next = w_step ? ST_RST_ON : ST_ISO_ON;
            ST_RST_ON:    w_next = w_step ? ST_SW_OFF : ST_RST_ON;
            ST_SW_OFF:    w_next = i_ack_n ? ST_OFF : (w_to ? ST_ERR : ST_SW_OFF);
            ST_OFF:       w_next = w_on_ok ? ST_SW_ON : ST_OFF;
            ST_SW_ON:     w_next = !i_ack_n ? ST_CLK_ON : (w_to ? ST_ERR : ST_SW_ON);
            ST_CLK_ON:    w_next = w_step ? ST_RST_REL : ST_CLK_ON;
            ST_RST_REL:   w_next = w_step ? ST_ON : ST_RST_REL;
            ST_ERR:       w_next = w_on_ok ? ST_SW_ON : ST_ERR;
            default:      w_next = ST_BOOT;
        endcase
    end

    always_comb begin
        o_ctl = (r_state == ST_ERR) ? r_err_ctl : ctl_of(r_state);
        o_on = r_state == ST_ON;
        o_off = r_state == ST_OFF;
        o_err = r_state == ST_ERR;
        o_busy = !(o_on || o_off || o_err);
        o_drop = r_drop;
    end

endmodule

// File: rtl/ext_pwr_seq_ctrl.sv
// ext_pwr_seq_ctrl: independent power-down/power-up sequencers for the external subsystem domains.
module ext_pwr_seq_ctrl
    import ext_pwr_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = 1,
    parameter int STEP_CYCLES = DEF_STEP_CYCLES,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_DOMAINS-1:0] pwr_off_req_i,
    input  logic [NUM_DOMAINS-1:0] pwr_on_req_i,
    input  logic [NUM_DOMAINS-1:0] switch_ack_ni,
    output logic [NUM_DOMAINS-1:0] switch_no,
    output logic [NUM_DOMAINS-1:0] iso_no,
    output logic [NUM_DOMAINS-1:0] rst_no,
    output logic [NUM_DOMAINS-1:0] clkgate_en_no,
    output logic [NUM_DOMAINS-1:0] on_o,
    output logic [NUM_DOMAINS-1:0] off_o,
    output logic [NUM_DOMAINS-1:0] busy_o,
    output logic [NUM_DOMAINS-1:0] err_o,
    output logic [NUM_DOMAINS-1:0] req_drop_o
);
    for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_dom
        logic [3:0] w_ctl;
        ext_pwr_domain_fsm #(
            .STEP_CYCLES(STEP_CYCLES),
            .ACK_TIMEOUT(ACK_TIMEOUT)
        ) u_fsm (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .i_off_req(pwr_off_req_i[d]),
            .i_on_req (pwr_on_req_i[d]),
            .i_ack_n  (switch_ack_ni[d]),
            .o_ctl    (w_ctl),
            .o_on     (on_o[d]),
            .o_off    (off_o[d]),
            .o_busy   (busy_o[d]),
            .o_err    (err_o[d]),
            .o_drop   (req_drop_o[d])
        );
        assign {switch_no[d], iso_no[d], rst_no[d], clkgate_en_no[d]} = w_ctl;
    end

endmodule

// File: doc/ext_pwr_seq_ctrl.md
Name: ext_pwr_seq_ctrl

Overview:
Power-domain sequencer for the external subsystem domains of CB_heep.
- Accepts power-off and power-on requests per domain.
- Drives the external_subsystem_* control bundle in a fixed, timed order: clock gate, isolation, reset, power switch.
- Waits on the switch acknowledge, with a timeout.
- Sits between a software-visible request source (register interface or test harness) and the external_subsystem_powergate_* / rst / clkgate pins of the top level.

Parameters:
NUM_DOMAINS, 1, number of independent external power domains; one sequencer FSM per domain.
STEP_CYCLES, 4, cycles each intermediate step is held before the next step starts (>=1).
ACK_TIMEOUT, 64, maximum cycles to wait for a switch acknowledge before flagging an error (> STEP_CYCLES).

Ports:
clk_i  in  1  system clock.
rst_i  in  1  synchronous, active-high reset.
pwr_off_req_i  in  NUM_DOMAINS  one-cycle pulse per domain: start the power-down sequence.
pwr_on_req_i  in  NUM_DOMAINS  one-cycle pulse per domain: start the power-up sequence.
switch_ack_ni  in  NUM_DOMAINS  switch acknowledge, active low (0 = powered).
switch_no  out  NUM_DOMAINS  power switch control, active low (0 = on).
iso_no  out  NUM_DOMAINS  isolation, active low (0 = isolated).
rst_no  out  NUM_DOMAINS  domain reset, active low.
clkgate_en_no  out  NUM_DOMAINS  clock gate, active low (0 = clock gated).
on_o  out  NUM_DOMAINS  domain fully on (state ON).
off_o  out  NUM_DOMAINS  domain fully off (state OFF).
busy_o  out  NUM_DOMAINS  sequence in progress.
err_o  out  NUM_DOMAINS  sticky acknowledge-timeout flag.
req_drop_o  out  NUM_DOMAINS  one-cycle pulse: a request was ignored.

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high.
- Outputs are a combinational decode of the registered state. An output changes in the cycle after the state transition edge.
- Each domain runs its own FSM and counter. There is no interaction between domains.

States and output values (switch_no, iso_no, rst_no, clkgate_en_no):
- BOOT: 0, 0, 0, 1. This is the reset state for every domain.
- ON: 0, 1, 1, 1.
- CLK_OFF: 0, 1, 1, 0.
- ISO_ON: 0, 0, 1, 0.
- RST_ON: 0, 0, 0, 0.
- SW_OFF: 1, 0, 0, 0.
- OFF: 1, 0, 0, 0.
- SW_ON: 0, 0, 0, 0.
- CLK_ON: 0, 0, 0, 1.
- RST_REL: 0, 0, 1, 1.
- ERR: outputs of the state in which the timeout occurred are held.

Reset values:
- While rst_i is high: all domains in BOOT, counters 0, err_o=0, req_drop_o=0, on_o=0, off_o=0, busy_o=1.
- BOOT waits for switch_ack_ni=0, then holds STEP_CYCLES more cycles, then goes to ON.
- If the ack is missing for ACK_TIMEOUT cycles, go to ERR.

Power-off sequence:
- Accepted only in ON: ON -> CLK_OFF -> ISO_ON -> RST_ON -> SW_OFF -> OFF.
- CLK_OFF, ISO_ON and RST_ON each last exactly STEP_CYCLES cycles.
- SW_OFF exits the cycle after switch_ack_ni is sampled 1.

Power-on sequence:
- Accepted in OFF or ERR: SW_ON -> CLK_ON -> RST_REL -> ON.
- SW_ON exits the cycle after switch_ack_ni is sampled 0.
- CLK_ON and RST_REL each last STEP_CYCLES cycles.

Timeout:
- The counter restarts at 0 on entering SW_OFF, SW_ON or BOOT.
- If the counter reaches ACK_TIMEOUT without the expected ack: go to ERR and set err_o.
- err_o clears only on rst_i or on an accepted pwr_on_req.

Status flags:
- busy_o = state not in {ON, OFF, ERR}.
- on_o = state is ON; off_o = state is OFF.

Request handling:
- A request in any other state (busy, wrong direction, off_req in OFF or ERR) is ignored; req_drop_o pulses.
- Requests are never queued.
- Simultaneous off_req and on_req to one domain: both are ignored and req_drop_o pulses.

Other boundary conditions:
- Ack glitches while waiting count only when sampled.
- Ack already at its target value on entering a wait state: the state exits after 1 cycle.
- Counter width is clog2(max(STEP_CYCLES, ACK_TIMEOUT)+1). The counter saturates and never wraps.

Decomposition:
- Package ext_pwr_seq_pkg holds:
  - the state enum;
  - an output-decode function returning the 4-bit control vector per state;
  - the counter-width localparam.
- Sub-module ext_pwr_domain_fsm holds one domain: FSM, counter and output decode.
- The top instantiates it NUM_DOMAINS times in a generate loop.

Test Plan:
Common setup: STEP_CYCLES=4, ACK_TIMEOUT=32. The bench acks every switch change after 15 cycles.
1. Reset release (rst_i low at cycle 0) -> ack already 0 -> BOOT exits after 1 cycle, then 4 cycles of hold; on_o=1 at cycle 6 (after ack seen at cycle 1); rst_no rises at the same cycle; err_o=0.
2. pwr_off_req pulse at cycle T:
   - clkgate_en_no=0 at T+1, iso_no=0 at T+5, rst_no=0 at T+9, switch_no=1 at T+13;
   - ack at T+28; off_o=1 at T+29; busy_o=1 from T+1 to T+28.
3. pwr_on_req in OFF at cycle T:
   - switch_no=0 at T+1; ack 0 at T+16;
   - clkgate_en_no=1 at T+17, rst_no=1 at T+21, iso_no=1 and on_o=1 at T+25.
4. Ack never returns after off_req:
   - ERR with err_o=1 exactly 32 cycles after SW_OFF entry; switch_no stays 1;
   - a subsequent on_req clears err_o and completes the power-on sequence.
5. Drop cases, each giving a req_drop_o single-cycle pulse with no state change:
   - off_req during CLK_OFF;
   - on_req and off_req in the same cycle in ON;
   - on_req in ON.
6. NUM_DOMAINS=2: off_req to domain 0 and on_req to domain 1 (already OFF) in the same cycle -> both sequences run independently with the timing of scenarios 2 and 3.
